// File: rtl/rf_dumper.sv
// rf_dumper: walks a register file one index at a time through a
// combinational read port and streams each captured value out as a
// valid/ready beat. One register is in flight at a time, so beats are
// never back-to-back. Abort drops the dump silently; the last beat
// is followed by a one-cycle done pulse.
module rf_dumper #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [4:0]    rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  localparam logic [4:0] LAST = 5'(NREGS - 1);

  state_t        state_q;
  logic [4:0]    idx_q;
  logic [4:0]    rd_addr_q;
  logic [4:0]    out_idx_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          done_q;

  // Dump sequencer. Every output is a register. rd_addr is loaded
  // with the index about to be read on the edge that enters READ,
  // and cleared on any edge that leaves READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // abort is deliberately not looked at here
          if (start) begin
            state_q   <= READ;
            idx_q     <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        READ: begin
          rd_addr_q <= '0;
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            out_data_q  <= rd_data;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // abort wins over a coincident handshake: the beat is gone
          // downstream, but the dump ends quietly in IDLE
          if (abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q     <= idx_q + 5'd1;
              rd_addr_q <= idx_q + 5'd1;
              state_q   <= READ;
            end
          end
        end
        DONE: begin
          // start and abort are both ignored for this one cycle
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          rd_addr_q   <= '0;
        end
      endcase
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
